// File: rtl/aes_pkg.sv
// Shared types, round constants and GF(2^8) helpers for the AES-128 key schedule.
package aes_pkg;

   typedef logic [31:0]  aes_word_t;
   typedef logic [127:0] aes_key128_t;

   typedef enum logic [1:0] {IDLE, OUT, CALC} aes_ks_state_t;

   localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   function automatic logic [7:0] rcon_of(input logic [3:0] r);
      logic [7:0] c;
      c = '0;
      if (r >= 4'd1 && r <= 4'd10) c = RCON[r];
      return c;
   endfunction

   // Multiply modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_key_expand128_pipe_subword.sv
// SubWord: four parallel combinational S-boxes, implementation chosen by SBOX_SEL.
module aes_subword
   import aes_pkg::*;
#(
   parameter int SBOX_SEL = 0
) (
   input  aes_word_t word_i,
   output aes_word_t word_o
);
   if (SBOX_SEL < 0 || SBOX_SEL > 2) begin : g_bad_sel
      $error("aes_subword: unsupported SBOX_SEL %0d", SBOX_SEL);
   end

   for (genvar i = 0; i < 4; i++) begin : g_byte
      if (SBOX_SEL == 0) begin : g_113
         aes_sbox_g113 u_sbox (.in_i(word_i[8*i +: 8]), .out_o(word_o[8*i +: 8]));
      end else if (SBOX_SEL == 1) begin : g_115
         aes_sbox_g115 u_sbox (.in_i(word_i[8*i +: 8]), .out_o(word_o[8*i +: 8]));
      end else begin : g_128
         aes_sbox_g128 u_sbox (.in_i(word_i[8*i +: 8]), .out_o(word_o[8*i +: 8]));
      end
   end
endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box variants; they differ only in how the field inverse
// and the affine map are built, and are functionally identical.
module aes_sbox_g113
   import aes_pkg::*;
(
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);
   logic [7:0] sq;
   logic [7:0] inv;

   // x^254 as the product of x^2, x^4, ..., x^128.
   always_comb begin
      sq  = in_i;
      inv = 8'h01;
      for (int unsigned k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      out_o = sbox_affine(inv);
   end
endmodule

module aes_sbox_g115
   import aes_pkg::*;
(
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);
   logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, x254;

   assign x2   = gf_mul(in_i, in_i);
   assign x3   = gf_mul(x2, in_i);
   assign x6   = gf_mul(x3, x3);
   assign x12  = gf_mul(x6, x6);
   assign x15  = gf_mul(x12, x3);
   assign x30  = gf_mul(x15, x15);
   assign x60  = gf_mul(x30, x30);
   assign x120 = gf_mul(x60, x60);
   assign x240 = gf_mul(x120, x120);
   assign x252 = gf_mul(x240, x12);
   assign x254 = gf_mul(x252, x2);
   assign out_o = sbox_affine(x254);
endmodule

module aes_sbox_g128
   import aes_pkg::*;
(
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);
   logic [7:0] t;
   logic [7:0] inv;

   // x^127 by repeated square-and-multiply, squared once more for x^254.
   always_comb begin
      t = in_i;
      for (int unsigned k = 0; k < 6; k++) begin
         t = gf_mul(gf_mul(t, t), in_i);
      end
      inv = gf_mul(t, t);
      for (int unsigned i = 0; i < 8; i++) begin
         out_o[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                  ^ inv[(i + 7) % 8];
      end
      out_o = out_o ^ 8'h63;
   end
endmodule

// File: rtl/aes_key_expand128_pipe.sv
// Iterative AES-128 key schedule emitting round keys 0..10 over a valid/ready handshake.
module aes_key_expand128_pipe
   import aes_pkg::*;
#(
   parameter int SBOX_SEL    = 0,
   parameter int SUBWORD_REG = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key,
   output logic [127:0] rk,
   output logic [3:0]   rk_round,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         busy,
   output logic         done
);
   aes_ks_state_t state_q;
   aes_key128_t   rk_q;
   aes_key128_t   rk_d;
   logic [3:0]    round_q;
   logic          valid_q;
   logic          busy_q;
   logic          done_q;
   aes_word_t     sw_q;
   aes_word_t     sw_comb;
   aes_word_t     sw_use;
   aes_word_t     t;
   aes_word_t     w0, w1, w2, w3;
   aes_word_t     n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = rk_q;

   aes_subword #(.SBOX_SEL(SBOX_SEL)) u_subword (
      .word_i({w3[23:0], w3[31:24]}),
      .word_o(sw_comb)
   );

   // With SUBWORD_REG the S-box result is taken from the register loaded in OUT.
   assign sw_use = (SUBWORD_REG != 0) ? sw_q : sw_comb;

   always_comb begin
      t    = sw_use ^ {rcon_of(round_q + 4'd1), 24'h0};
      n0   = w0 ^ t;
      n1   = w1 ^ n0;
      n2   = w2 ^ n1;
      n3   = w3 ^ n2;
      rk_d = {n0, n1, n2, n3};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rk_q    <= '0;
         round_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sw_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  rk_q    <= key;
                  round_q <= '0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= OUT;
               end
            end
            OUT: begin
               if (valid_q && rk_ready) begin
                  if (round_q == 4'd10) begin
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else if (SUBWORD_REG != 0) begin
                     sw_q    <= sw_comb;
                     valid_q <= 1'b0;
                     state_q <= CALC;
                  end else begin
                     rk_q    <= rk_d;
                     round_q <= round_q + 4'd1;
                  end
               end
            end
            CALC: begin
               rk_q    <= rk_d;
               round_q <= round_q + 4'd1;
               valid_q <= 1'b1;
               state_q <= OUT;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rk       = rk_q;
   assign rk_round = round_q;
   assign rk_valid = valid_q;
   assign busy     = busy_q;
   assign done     = done_q;
endmodule

// File: doc/aes_key_expand128_pipe.md
Name: aes_key_expand128_pipe

Overview:
- Iterative AES-128 key schedule. Produces the 11 round keys (round 0..10), one per accepted handshake, for the round datapath that sits downstream.
- Consumes the combinational forward S-box modules directly: four instances implement SubWord.
- An optional register after SubWord cuts the S-box critical path, so the block can follow the pipelined round stages in timing.

Parameters:
- SBOX_SEL, 0, S-box implementation: 0 = aes_sbox_g113, 1 = aes_sbox_g115, 2 = aes_sbox_g128. Any other value is a elaboration error.
- SUBWORD_REG, 0, 1 inserts a pipeline register on the SubWord output (two cycles per round key instead of one).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- key  in  128  cipher key; byte 0 = key[127:120]; sampled when start is accepted.
- rk  out  128  current round key, same byte order as key.
- rk_round  out  4  round index of rk, 0..10.
- rk_valid  out  1  rk/rk_round are valid.
- rk_ready  in  1  consumer accepts when rk_valid && rk_ready.
- busy  out  1  high from start acceptance until the round-10 key is accepted.
- done  out  1  one-cycle pulse the cycle after the round-10 key is accepted.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: rk = 0, rk_round = 0, rk_valid = 0, busy = 0, done = 0. FSM goes to IDLE.
- FSM states: IDLE, OUT, CALC. CALC is reachable only when SUBWORD_REG = 1.
- IDLE:
  - On start: rk <= key, rk_round <= 0, rk_valid <= 1, busy <= 1, go to OUT.
  - Round 0 is therefore visible one cycle after start.
- OUT with rk_valid && !rk_ready: rk, rk_round and rk_valid hold stable; no computation advances.
- OUT, handshake with rk_round = 10: rk_valid <= 0, busy <= 0, done <= 1 for one cycle, go to IDLE. rk keeps its last value.
- OUT, handshake with rk_round < 10, SUBWORD_REG = 0:
  - Load the next key in the same edge: rk_round <= rk_round + 1; rk_valid stays 1.
  - Back-to-back accepts yield one key per cycle; all 11 keys take 11 accepted cycles.
- OUT, handshake with rk_round < 10, SUBWORD_REG = 1:
  - Register SubWord(RotWord(w3)), drop rk_valid, go to CALC.
  - CALC completes the XOR chain, increments rk_round, raises rk_valid, and returns to OUT.
  - Cost is two cycles per key after the first.
- Next-key math (w0..w3 = rk words, w0 = rk[127:96]):
  - t = SubWord(RotWord(w3)) ^ {RCON[rk_round+1], 24'h0}, where RotWord is a left byte rotate.
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
- RCON for rounds 1..10: 01 02 04 08 10 20 40 80 1b 36.
- S-box byte ordering is standard: in[7] is the MSB of the AES byte. The S-box modules handle any internal bit reversal.
- start while busy is ignored, with no effect on state.
- start in the same cycle as the done pulse: done is asserted in that cycle with the FSM already in IDLE, so start is accepted normally.
- rk_ready while rk_valid = 0 is ignored.
- Reset asserted mid-expansion aborts immediately to the reset values. No done pulse is produced.

Decomposition:
- Package aes_pkg:
  - typedef aes_word_t (logic [31:0]);
  - typedef aes_key128_t (logic [127:0]);
  - RCON constant array [1:10];
  - FSM state enum (IDLE, OUT, CALC).
- Sub-module aes_subword: four parallel S-box instances selected by SBOX_SEL through a generate block; purely combinational.
- Top level: FSM, rk register, optional SubWord register, XOR chain.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready held 1, SUBWORD_REG = 0:
  - round 0 equals key;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - 11 consecutive valid cycles, then done pulses once.
- Same key with SUBWORD_REG = 1:
  - identical key sequence;
  - rk_valid low for exactly one cycle between keys;
  - done 21 cycles after the first rk_valid.
- Random rk_ready stalls (about 50%) on key 000102030405060708090a0b0c0d0e0f:
  - rk stays stable while stalled;
  - round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- start pulsed at round 4 with a different key: ignored; sequence completes for the original key.
- rst_n asserted at round 6:
  - all outputs return to 0 asynchronously; no done pulse;
  - a new start afterwards gives a correct round 0 and round 1.
- Repeat the first scenario for SBOX_SEL = 0, 1 and 2: bit-identical outputs.
